// File: rtl/frame_sequencer_if.sv
// Handshake and data bundle between the frame sequencer, its payload source
// and the downstream line stage. The master modport is the sequencer side.
interface frame_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              i_en;
  logic [DATA_W-1:0] i_pld_data;
  logic              i_pld_valid;
  logic              o_pld_ready;
  logic              i_line_ready;
  logic [DATA_W-1:0] o_frame_data;
  logic              o_frame_data_valid;
  logic              o_frame_data_fas;
  logic [1:0]        o_row_cnt;
  logic [10:0]       o_col_cnt;
  logic [15:0]       o_frame_cnt;
  logic              o_busy;
  logic              o_underrun;

  modport master (
    input  i_en, i_pld_data, i_pld_valid, i_line_ready,
    output o_pld_ready, o_frame_data, o_frame_data_valid, o_frame_data_fas,
           o_row_cnt, o_col_cnt, o_frame_cnt, o_busy, o_underrun
  );

  modport slave (
    output i_en, i_pld_data, i_pld_valid, i_line_ready,
    input  o_pld_ready, o_frame_data, o_frame_data_valid, o_frame_data_fas,
           o_row_cnt, o_col_cnt, o_frame_cnt, o_busy, o_underrun
  );
endinterface

// File: rtl/frame_sequencer.sv
// Builds ROWS x COLS frames (overhead, payload, tail byte) into a one-beat output register.
// Optional macro FRAME_SEQ_UNDERRUN_FILL_EN: payload starvation inserts 0x00 fill beats.
module frame_sequencer #(
  parameter int ROWS    = 4,
  parameter int COLS    = 1041,
  parameter int OH_COLS = 16,
  parameter int DATA_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  frame_sequencer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, OH, PLD, TAIL} state_t;

  localparam logic [1:0]  LAST_ROW = 2'(ROWS - 1);
  localparam logic [10:0] OH_LAST  = 11'(OH_COLS - 1);
  localparam logic [10:0] PLD_LAST = 11'(COLS - 2);

  function automatic logic [DATA_W-1:0] oh_byte(input logic [1:0] r, input logic [10:0] c);
    if (r == 2'd0 && c < 11'd3) return DATA_W'(8'hF6);
    if (r == 2'd0 && c < 11'd6) return DATA_W'(8'h28);
    return '0;
  endfunction

  state_t            state, state_nxt;
  logic [1:0]        row, row_nxt;
  logic [10:0]       col, col_nxt;
  logic [DATA_W-1:0] beat;
  logic              have_beat, load_ok, load, frame_done;

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1, fas_p1;
  logic [1:0]        row_p1;
  logic [10:0]       col_p1;
  logic [15:0]       frame_cnt;
`ifdef FRAME_SEQ_UNDERRUN_FILL_EN
  logic              fill;
  logic              underrun_p1;
`endif

  // Stage p0: next-beat selection and position bookkeeping
  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    col_nxt    = col;
    beat       = '0;
    have_beat  = 1'b0;
    frame_done = 1'b0;
`ifdef FRAME_SEQ_UNDERRUN_FILL_EN
    fill       = 1'b0;
`endif
    load_ok    = !vld_p1 || bus.i_line_ready;

    case (state)
      OH: begin
        have_beat = 1'b1;
        beat      = oh_byte(row, col);
      end
      PLD: begin
        have_beat = bus.i_pld_valid;
        beat      = bus.i_pld_data;
`ifdef FRAME_SEQ_UNDERRUN_FILL_EN
        if (!bus.i_pld_valid) begin
          have_beat = 1'b1;
          beat      = '0;
          fill      = 1'b1;
        end
`endif
      end
      TAIL:    have_beat = 1'b1;
      default: have_beat = 1'b0;
    endcase

    load = load_ok && have_beat;

    case (state)
      IDLE: begin
        if (bus.i_en) begin
          state_nxt = OH;
          row_nxt   = 2'd0;
          col_nxt   = 11'd0;
        end
      end
      OH: begin
        if (load) begin
          col_nxt = col + 11'd1;
          if (col == OH_LAST) state_nxt = PLD;
        end
      end
      PLD: begin
        if (load) begin
          col_nxt = col + 11'd1;
          if (col == PLD_LAST) state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (load) begin
          col_nxt = 11'd0;
          if (row == LAST_ROW) begin
            // i_en is only looked at here and in IDLE, so a frame always completes
            row_nxt    = 2'd0;
            frame_done = 1'b1;
            state_nxt  = bus.i_en ? OH : IDLE;
          end else begin
            row_nxt   = row + 2'd1;
            state_nxt = OH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: output beat register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      row       <= 2'd0;
      col       <= 11'd0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      fas_p1    <= 1'b0;
      row_p1    <= 2'd0;
      col_p1    <= 11'd0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      frame_cnt <= frame_cnt + 16'(frame_done);
      if (load) begin
        data_p1 <= beat;
        vld_p1  <= 1'b1;
        fas_p1  <= (state == OH) && (row == 2'd0) && (col == 11'd0);
        row_p1  <= row;
        col_p1  <= col;
      end else if (bus.i_line_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

`ifdef FRAME_SEQ_UNDERRUN_FILL_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) underrun_p1 <= 1'b0;
    else       underrun_p1 <= load && fill;
  end
  assign bus.o_underrun = underrun_p1;
`else
  assign bus.o_underrun = 1'b0;
`endif

  assign bus.o_pld_ready        = (state == PLD) && load_ok;
  assign bus.o_frame_data       = data_p1;
  assign bus.o_frame_data_valid = vld_p1;
  assign bus.o_frame_data_fas   = fas_p1;
  assign bus.o_row_cnt          = row_p1;
  assign bus.o_col_cnt          = col_p1;
  assign bus.o_frame_cnt        = frame_cnt;
  assign bus.o_busy             = (state != IDLE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: payload bytes are queued as they are
// accepted and popped in order as output beats are taken downstream.
module tb_frame_sequencer;

  localparam int ROWS    = 4;
  localparam int COLS    = 1041;
  localparam int OH_COLS = 16;
  localparam int LIMIT   = 20000;

  logic clk = 1'b0;
  logic rst;

  frame_sequencer_if #(.DATA_W(8)) bus ();

  frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .OH_COLS(OH_COLS), .DATA_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         exp_row = 0, exp_col = 0;
  int         frames_done = 0, beats = 0, first_cyc = 0;
  logic [7:0] pld_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh_ref(input int r, input int c);
    if (r == 0 && c < 3) return 8'hF6;
    if (r == 0 && c < 6) return 8'h28;
    return 8'h00;
  endfunction

  task automatic consume();
    logic [7:0] exp_d;
    logic       exp_u;
    exp_u = 1'b0;
    if (exp_col < OH_COLS)        exp_d = oh_ref(exp_row, exp_col);
    else if (exp_col == COLS - 1) exp_d = 8'h00;
    else if (pld_q.size() > 0)    exp_d = pld_q.pop_front();
    else begin
      exp_d = 8'h00;
      exp_u = 1'b1;
    end
    check("beat_data", 32'(bus.o_frame_data), 32'(exp_d));
    check("beat_row", 32'(bus.o_row_cnt), 32'(exp_row));
    check("beat_col", 32'(bus.o_col_cnt), 32'(exp_col));
    check("beat_fas", 32'(bus.o_frame_data_fas), 32'(exp_row == 0 && exp_col == 0));
    check("beat_underrun", 32'(bus.o_underrun), 32'(exp_u));
    if (exp_row == 0 && exp_col == 0) first_cyc = cyc;
    beats++;
    if (exp_col == COLS - 1) begin
      exp_col = 0;
      if (exp_row == ROWS - 1) begin
        exp_row = 0;
        check("frame_cnt_at_end", 32'(bus.o_frame_cnt), 32'(frames_done + 1));
        check("beats_per_frame", 32'(beats), 32'(ROWS * COLS));
        if (frames_done == 0) check("frame1_contiguous", 32'(cyc - first_cyc), 32'(ROWS * COLS - 1));
        frames_done++;
        beats = 0;
      end else begin
        exp_row++;
      end
    end else begin
      exp_col++;
    end
  endtask

  // One clock: observe the transfers of the coming edge, then advance the source.
  task automatic cycle();
    logic fire_in;
    @(negedge clk);
    cyc++;
    if (bus.o_frame_data_valid && bus.i_line_ready) consume();
    fire_in = bus.i_pld_valid && bus.o_pld_ready;
    if (fire_in) pld_q.push_back(bus.i_pld_data);
    @(posedge clk);
    #1;
    if (fire_in) bus.i_pld_data = bus.i_pld_data + 8'd1;
  endtask

  task automatic wait_at(input int r, input int c);
    int n;
    n = 0;
    while (!(bus.o_frame_data_valid && bus.o_row_cnt == 2'(r) && bus.o_col_cnt == 11'(c)) && n < LIMIT) begin
      cycle();
      n++;
    end
    check("wait_position", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic wait_frames(input int k);
    int n;
    n = 0;
    while (bus.o_frame_cnt != 16'(k) && n < LIMIT) begin
      cycle();
      n++;
    end
    check("wait_frame_cnt", 32'(bus.o_frame_cnt), 32'(k));
  endtask

  task automatic check_reset_state();
    check("rst_data", 32'(bus.o_frame_data), 32'h0);
    check("rst_valid", 32'(bus.o_frame_data_valid), 32'h0);
    check("rst_fas", 32'(bus.o_frame_data_fas), 32'h0);
    check("rst_row", 32'(bus.o_row_cnt), 32'h0);
    check("rst_col", 32'(bus.o_col_cnt), 32'h0);
    check("rst_frame_cnt", 32'(bus.o_frame_cnt), 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'h0);
    check("rst_underrun", 32'(bus.o_underrun), 32'h0);
    check("rst_pld_ready", 32'(bus.o_pld_ready), 32'h0);
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    bus.i_en         = 1'b0;
    bus.i_pld_data   = 8'h00;
    bus.i_pld_valid  = 1'b1;
    bus.i_line_ready = 1'b1;
    cycle();
    cycle();
    check_reset_state();
    rst = 1'b0;
    cycle();
    check("idle_busy", 32'(bus.o_busy), 32'h0);
    check("idle_valid", 32'(bus.o_frame_data_valid), 32'h0);

    // Frame 1: free-running, all handshakes asserted
    bus.i_en = 1'b1;
    wait_frames(1);

    // Frame 2: downstream backpressure at (1,500)
    wait_at(1, 500);
    bus.i_line_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_row", 32'(bus.o_row_cnt), 32'd1);
      check("bp_col", 32'(bus.o_col_cnt), 32'd500);
      check("bp_valid", 32'(bus.o_frame_data_valid), 32'd1);
      check("bp_pld_ready", 32'(bus.o_pld_ready), 32'd0);
    end
    bus.i_line_ready = 1'b1;

    // Frame 2: payload starvation for the beats at (2,100..102)
    wait_at(2, 99);
    bus.i_pld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
`ifdef FRAME_SEQ_UNDERRUN_FILL_EN
      check("fill_col", 32'(bus.o_col_cnt), 32'(100 + i));
      check("fill_data", 32'(bus.o_frame_data), 32'h0);
      check("fill_underrun", 32'(bus.o_underrun), 32'd1);
`else
      check("stall_valid", 32'(bus.o_frame_data_valid), 32'd0);
      check("stall_pld_ready", 32'(bus.o_pld_ready), 32'd1);
`endif
    end
    bus.i_pld_valid = 1'b1;
    wait_frames(2);

    // Frame 3: enable dropped mid-frame, frame must still complete
    wait_at(1, 20);
    bus.i_en = 1'b0;
    n = 0;
    while (bus.o_busy && n < LIMIT) begin
      cycle();
      n++;
    end
    check("drain_busy", 32'(bus.o_busy), 32'd0);
    check("drain_frame_cnt", 32'(bus.o_frame_cnt), 32'd3);
    cycle();
    cycle();
    check("drain_valid", 32'(bus.o_frame_data_valid), 32'd0);
    check("drain_frames_seen", 32'(frames_done), 32'd3);
    check("drain_exp_col", 32'(exp_col), 32'd0);

    // Frame 4: reset pulsed at (2,300) abandons the frame
    bus.i_en = 1'b1;
    wait_at(2, 300);
    rst = 1'b1;
    cycle();
    check_reset_state();
    rst = 1'b0;
    pld_q.delete();
    exp_row     = 0;
    exp_col     = 0;
    frames_done = 0;
    beats       = 0;
    n = 0;
    while (!bus.o_frame_data_valid && n < 20) begin
      cycle();
      n++;
    end
    check("restart_valid", 32'(bus.o_frame_data_valid), 32'd1);
    check("restart_row", 32'(bus.o_row_cnt), 32'd0);
    check("restart_col", 32'(bus.o_col_cnt), 32'd0);
    check("restart_fas", 32'(bus.o_frame_data_fas), 32'd1);
    check("restart_data", 32'(bus.o_frame_data), 32'hF6);
    repeat (300) cycle();
    check("restart_progress", 32'(beats > 250), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
